// File: rtl/histogram_equalizer_stream.sv
// Two-pass streaming histogram equaliser: count, build CDF/LUT, then remap the replayed frame.
// Optional HIST_READBACK_EN adds a registered histogram read port.
module histogram_equalizer_stream #(
  parameter int PIX_W   = 8,
  parameter int NUM_PIX = 76800,
  parameter int CNT_W   = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
`ifdef HIST_READBACK_EN
  input  logic [PIX_W-1:0] hist_rd_addr,
  output logic [CNT_W-1:0] hist_rd_data,
`endif
  output logic             done
);
  localparam int BINS = 1 << PIX_W;
  localparam int MW   = CNT_W + PIX_W;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0] NPIX     = CNT_W'(NUM_PIX);
  localparam logic [MW-1:0]    SCALE_K  = MW'(BINS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_CDF, S_SCALE, S_MAP} state_t;

  state_t           state, state_nxt;
  logic [PIX_W-1:0] bin;
  logic [CNT_W-1:0] pix_cnt, out_cnt;
  logic [CNT_W-1:0] cdf_acc, cdf_acc_nxt, cdf_min;
  logic             min_found;

  logic [CNT_W-1:0] hist [BINS];
  logic [CNT_W-1:0] cdf  [BINS];
  logic [PIX_W-1:0] lut  [BINS];

  logic             in_acc, out_acc, last_bin;
  logic [CNT_W-1:0] den;
  logic [MW-1:0]    num, quo;
  logic [PIX_W-1:0] lut_val;

  assign last_bin    = (bin == {PIX_W{1'b1}});
  assign in_acc      = in_valid && in_ready;
  assign out_acc     = out_valid && out_ready;
  assign cdf_acc_nxt = cdf_acc + hist[bin];
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_MAP) && out_acc && (out_cnt == LAST_PIX);

  // MAP stops accepting once the whole frame is in, so extra pixels cannot leak through.
  always_comb begin
    in_ready = 1'b0;
    if (state == S_ACCUM) in_ready = 1'b1;
    else if (state == S_MAP) in_ready = (pix_cnt != NPIX) && (!out_valid || out_ready);
  end

  always_comb begin
    den     = NPIX - cdf_min;
    num     = MW'(cdf[bin] - cdf_min) * SCALE_K;
    quo     = '0;
    lut_val = '0;
    if (den == '0) lut_val = bin;
    else if (cdf[bin] >= cdf_min) begin
      quo     = num / MW'(den);
      lut_val = PIX_W'(quo);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: if (last_bin) state_nxt = S_ACCUM;
      S_ACCUM: if (in_acc && pix_cnt == LAST_PIX) state_nxt = S_CDF;
      S_CDF:   if (last_bin) state_nxt = S_SCALE;
      S_SCALE: if (last_bin) state_nxt = S_MAP;
      S_MAP:   if (done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bin       <= '0;
      pix_cnt   <= '0;
      out_cnt   <= '0;
      cdf_acc   <= '0;
      cdf_min   <= '0;
      min_found <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      bin   <= (state == S_CLEAR || state == S_CDF || state == S_SCALE) ? bin + 1'b1 : '0;
      if (state == S_ACCUM || state == S_MAP) begin
        if (in_acc) pix_cnt <= (state == S_ACCUM && pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
      end else begin
        pix_cnt <= '0;
      end
      out_cnt <= (state == S_MAP) ? (out_acc ? out_cnt + 1'b1 : out_cnt) : '0;
      if (state == S_CLEAR) begin
        cdf_acc   <= '0;
        min_found <= 1'b0;
      end else if (state == S_CDF) begin
        cdf_acc <= cdf_acc_nxt;
        if (!min_found && cdf_acc_nxt != '0) begin
          cdf_min   <= cdf_acc_nxt;
          min_found <= 1'b1;
        end
      end
      if (state == S_MAP && in_acc) begin
        out_valid <= 1'b1;
        out_data  <= lut[in_data];
      end else if (out_acc || state != S_MAP) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Histogram updates are a same-cycle read-modify-write on a flop array, so
  // back-to-back identical pixels always see the previous increment without a bypass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        S_CLEAR: hist[bin] <= '0;
        S_ACCUM: if (in_valid) hist[in_data] <= hist[in_data] + 1'b1;
        S_CDF:   cdf[bin]  <= cdf_acc_nxt;
        S_SCALE: lut[bin]  <= lut_val;
        default: ;
      endcase
    end
  end

`ifdef HIST_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst || state == S_CLEAR) hist_rd_data <= '0;
    else hist_rd_data <= hist[hist_rd_addr];
  end
`endif

endmodule

// File: tb/tb_histogram_equalizer_stream.sv
// Scoreboard bench for histogram_equalizer_stream (PIX_W=8, NUM_PIX=4).
module tb_histogram_equalizer_stream;
  localparam int PIX_W = 8, NUM_PIX = 4, CNT_W = 17, TMO = 3000;

  logic clk = 1'b0, rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [PIX_W-1:0] in_data, out_data;
`ifdef HIST_READBACK_EN
  logic [PIX_W-1:0] hist_rd_addr;
  logic [CNT_W-1:0] hist_rd_data;
`endif

  histogram_equalizer_stream #(.PIX_W(PIX_W), .NUM_PIX(NUM_PIX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy),
`ifdef HIST_READBACK_EN
    .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
`endif
    .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, done_cnt = 0, n_out = 0;
  logic [PIX_W-1:0] exp_q[$];
  bit stall_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  int cyc = 0;
  bit prev_stall = 1'b0;
  logic [PIX_W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = stall_mode ? pat[cyc % 4] : 1'b1;
    cyc++;
  end

  // Monitor: pops expected pixels on each output transfer and checks hold-while-stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual=%0d required=none", out_data);
        end else chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send_pass(input logic [3:0][7:0] px, input logic [3:0][7:0] ex, input bit push);
    for (int i = 0; i < NUM_PIX; i++) begin
      int g = 0;
      in_valid = 1'b1;
      in_data  = px[i];
      while (!in_ready && g < TMO) begin @(negedge clk); g++; end
      if (g >= TMO) begin timeout("in_ready"); in_valid = 1'b0; return; end
      if (push) exp_q.push_back(ex[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0][7:0] px, input logic [3:0][7:0] ex,
                           input bit stall, input bit poke_start, input bit readback);
    int g = 0;
    done_cnt = 0; n_out = 0; stall_mode = stall;
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    send_pass(px, ex, 1'b0);
`ifdef HIST_READBACK_EN
    if (readback) begin
      logic [3:0][7:0]  ra = {8'd0, 8'd30, 8'd20, 8'd10};
      logic [3:0][31:0] rd = {32'd0, 32'd1, 32'd1, 32'd2};
      for (int i = 0; i < 4; i++) begin
        hist_rd_addr = ra[i];
        @(negedge clk);
        chk("hist_readback", hist_rd_data, rd[i]);
      end
    end
`else
    if (readback) chk("no_readback_busy", busy, 1'b1);
`endif
    if (poke_start) begin
      while (!in_ready && g < TMO) begin @(negedge clk); g++; end
      start = 1'b1; @(negedge clk); start = 1'b0;
      g = 0;
    end
    send_pass(px, ex, 1'b1);
    while (!done && g < TMO) begin @(negedge clk); g++; end
    if (g >= TMO) timeout("done");
    else begin
      chk("busy_with_done", busy, 1'b1);
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
      chk("done_count", done_cnt, 1);
      chk("out_count", n_out, NUM_PIX);
      chk("queue_empty", exp_q.size(), 0);
    end
    stall_mode = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef HIST_READBACK_EN
    hist_rd_addr = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);

    // 1 + 6: basic frame with readback
    run_frame({8'd30, 8'd20, 8'd10, 8'd10}, {8'd255, 8'd127, 8'd0, 8'd0}, 1'b0, 1'b0, 1'b1);
    // 2: constant frame takes the identity path
    run_frame({8'd77, 8'd77, 8'd77, 8'd77}, {8'd77, 8'd77, 8'd77, 8'd77}, 1'b0, 1'b0, 1'b0);
    // 3: back-to-back identical pixels
    run_frame({8'd9, 8'd5, 8'd5, 8'd5}, {8'd255, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b0, 1'b0);
    // 4: downstream stalls
    run_frame({8'd30, 8'd20, 8'd10, 8'd10}, {8'd255, 8'd127, 8'd0, 8'd0}, 1'b1, 1'b0, 1'b0);

    // 5: abort mid-ACCUM, then a clean frame
    start = 1'b1; @(negedge clk); start = 1'b0;
    begin
      int g = 0;
      while (!in_ready && g < TMO) begin @(negedge clk); g++; end
      if (g >= TMO) timeout("abort_accum");
    end
    in_valid = 1'b1; in_data = 8'd30; @(negedge clk);
    in_data = 8'd20; @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    run_frame({8'd30, 8'd20, 8'd10, 8'd10}, {8'd255, 8'd127, 8'd0, 8'd0}, 1'b0, 1'b0, 1'b0);

    // 7: start pulsed during MAP is ignored
    run_frame({8'd30, 8'd20, 8'd10, 8'd10}, {8'd255, 8'd127, 8'd0, 8'd0}, 1'b0, 1'b1, 1'b0);
    chk("idle_after_poke", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
